// File: rtl/mor1kx_spram_pkg.sv
// mor1kx_spram_pkg: shared constants, clear-FSM encoding and lane parity helper
package mor1kx_spram_pkg;

   localparam int SPRAM_WRITE_FIRST = 0;
   localparam int SPRAM_READ_FIRST  = 1;
   localparam int SPRAM_NO_CHANGE   = 2;

   localparam int SPRAM_MAX_DW = 1024;
   localparam int SPRAM_MAX_NB = 128;

   typedef enum logic [0:0] {
      CLR_IDLE  = 1'b0,
      CLR_CLEAR = 1'b1
   } clr_state_t;

   // even parity per lane: bit i is the xor of lane i, so lane plus bit has an even count of ones
   function automatic logic [SPRAM_MAX_NB-1:0] lane_parity(input logic [SPRAM_MAX_DW-1:0] d,
                                                           input int bw, input int nb);
      logic [SPRAM_MAX_NB-1:0] p;
      p = '0;
      for (int i = 0; i < nb; i++)
         for (int j = 0; j < bw; j++)
            p[i] = p[i] ^ d[i*bw+j];
      return p;
   endfunction

endpackage

// File: rtl/mor1kx_spram_clr_seq.sv
// mor1kx_spram_clr_seq: post-reset clear sequencer and array port mux
module mor1kx_spram_clr_seq
   import mor1kx_spram_pkg::*;
#(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int NB             = 4,
   parameter int CLEAR_ON_RESET = 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [NB-1:0]         we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  busy,
   output logic [NB-1:0]         mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din
);

   clr_state_t            state, state_nxt;
   logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

   // state and counter registers; reset restarts the sweep from location 0
   always_ff @(posedge clk)
      if (rst) begin
         state <= (CLEAR_ON_RESET != 0) ? CLR_CLEAR : CLR_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end

   // sweep one location per cycle, leave after the last one is written
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (state == CLR_CLEAR && CLEAR_ON_RESET != 0) begin
         cnt_nxt = cnt + 1'b1;
         if (&cnt)
            state_nxt = CLR_IDLE;
      end else
         state_nxt = CLR_IDLE;
   end

   assign busy     = state == CLR_CLEAR;
   assign mem_we   = rst ? '0 : busy ? '1 : en ? we : '0;
   assign mem_addr = busy ? cnt : addr;
   assign mem_din  = busy ? '0 : din;

endmodule

// File: rtl/mor1kx_spram_bwe_clr.sv
// mor1kx_spram_bwe_clr: byte-enable single-port RAM with hardware clear; MOR1KX_SPRAM_PARITY_EN adds lane parity
module mor1kx_spram_bwe_clr
   import mor1kx_spram_pkg::*;
#(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int BYTE_WIDTH     = 8,
   parameter int WRITE_MODE     = 0,
   parameter int CLEAR_ON_RESET = 1
)(
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               en,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   we,
   input  logic [ADDR_WIDTH-1:0]              addr,
   input  logic [DATA_WIDTH-1:0]              din,
   output logic [DATA_WIDTH-1:0]              dout,
   output logic                               busy,
   output logic                               parity_err
);

   localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH = 2**ADDR_WIDTH;

   if (WRITE_MODE < SPRAM_WRITE_FIRST || WRITE_MODE > SPRAM_NO_CHANGE) begin : g_bad_mode
      $error("mor1kx_spram_bwe_clr: illegal WRITE_MODE");
   end
   if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $error("mor1kx_spram_bwe_clr: DATA_WIDTH not a multiple of BYTE_WIDTH");
   end

   logic [NB-1:0]         m_we;
   logic [ADDR_WIDTH-1:0] m_addr;
   logic [DATA_WIDTH-1:0] m_din;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] old_w, mrg_w;

   mor1kx_spram_clr_seq #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH),
      .NB            (NB),
      .CLEAR_ON_RESET(CLEAR_ON_RESET)
   ) u_clr_seq (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .we      (we),
      .addr    (addr),
      .din     (din),
      .busy    (busy),
      .mem_we  (m_we),
      .mem_addr(m_addr),
      .mem_din (m_din)
   );

   // old word at the request address and the word after merging enabled lanes
   always_comb begin
      old_w = mem[addr];
      mrg_w = old_w;
      for (int i = 0; i < NB; i++)
         if (we[i])
            mrg_w[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
   end

   // lane-masked array write, shared by user writes and the clear sweep
   always_ff @(posedge clk)
      for (int i = 0; i < NB; i++)
         if (m_we[i])
            mem[m_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= m_din[i*BYTE_WIDTH +: BYTE_WIDTH];

   // registered read data with collision behaviour selected by WRITE_MODE
   always_ff @(posedge clk)
      if (rst || busy)
         dout <= '0;
      else if (en)
         dout <= ~|we ? old_w :
                 WRITE_MODE == SPRAM_WRITE_FIRST ? mrg_w :
                 WRITE_MODE == SPRAM_READ_FIRST  ? old_w : dout;

`ifdef MOR1KX_SPRAM_PARITY_EN
   logic [NB-1:0] par [DEPTH];
   logic [NB-1:0] wr_par, old_bad;
   logic          perr;

   assign wr_par  = NB'(lane_parity(SPRAM_MAX_DW'(m_din), BYTE_WIDTH, NB));
   assign old_bad = par[addr] ^ NB'(lane_parity(SPRAM_MAX_DW'(old_w), BYTE_WIDTH, NB));

   // parity bits written alongside their lanes; the clear sweep stores parity of zero
   always_ff @(posedge clk)
      for (int i = 0; i < NB; i++)
         if (m_we[i])
            par[m_addr][i] <= wr_par[i];

   // parity error registered with dout, following the same collision rules
   always_ff @(posedge clk)
      if (rst || busy)
         perr <= 1'b0;
      else if (en)
         perr <= ~|we ? |old_bad :
                 WRITE_MODE == SPRAM_WRITE_FIRST ? 1'b0 :
                 WRITE_MODE == SPRAM_READ_FIRST  ? |old_bad : perr;

   assign parity_err = perr;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_mor1kx_spram_bwe_clr.sv
// tb_mor1kx_spram_bwe_clr: three collision modes driven in lockstep against an array model
module tb_mor1kx_spram_bwe_clr;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int NB    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst, en;
   logic [NB-1:0] we;
   logic [AW-1:0] addr;
   logic [DW-1:0] din;
   logic [DW-1:0] dout_v [3];
   logic [2:0]    busy_v, perr_v;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mor1kx_spram_bwe_clr #(
         .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
         .WRITE_MODE(g), .CLEAR_ON_RESET(1)
      ) dut (
         .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din),
         .dout(dout_v[g]), .busy(busy_v[g]), .parity_err(perr_v[g])
      );
   end

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] rmem  [3][DEPTH];
   logic [NB-1:0] rbad  [3][DEPTH];
   logic [DW-1:0] rdout [3];
   logic          rperr [3];
   bit            clearing;
   int            clr_idx;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [DW-1:0] old, nw;
      if (rst) begin
         clearing = 1;
         clr_idx  = 0;
         for (int m = 0; m < 3; m++) begin rdout[m] = '0; rperr[m] = 1'b0; end
      end else if (clearing) begin
         for (int m = 0; m < 3; m++) begin
            rmem[m][clr_idx] = '0;
            rbad[m][clr_idx] = '0;
            rdout[m] = '0;
            rperr[m] = 1'b0;
         end
         clr_idx++;
         if (clr_idx == DEPTH) clearing = 0;
      end else if (en) begin
         for (int m = 0; m < 3; m++) begin
            old = rmem[m][addr];
            nw  = old;
            for (int i = 0; i < NB; i++)
               if (we[i]) nw[i*8 +: 8] = din[i*8 +: 8];
            if (we == 0) begin
               rdout[m] = old;
               rperr[m] = |rbad[m][addr];
            end else begin
               if (m == 0) begin rdout[m] = nw; rperr[m] = 1'b0; end
               if (m == 1) begin rdout[m] = old; rperr[m] = |rbad[m][addr]; end
               rmem[m][addr] = nw;
               rbad[m][addr] = rbad[m][addr] & ~we;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      for (int m = 0; m < 3; m++) begin
         chk($sformatf("dout[%0d]", m), dout_v[m], rdout[m]);
         chk($sformatf("busy[%0d]", m), {31'b0, busy_v[m]}, {31'b0, clearing});
         chk($sformatf("perr[%0d]", m), {31'b0, perr_v[m]}, {31'b0, rperr[m]});
      end
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] w, input logic [DW-1:0] d);
      en = 1'b1; we = w; addr = a; din = d;
      step();
   endtask

   task automatic rd(input logic [AW-1:0] a);
      en = 1'b1; we = '0; addr = a; din = $urandom;
      step();
   endtask

   task automatic rnd_in();
      en   = 1'($urandom);
      we   = ($urandom % 3 == 0) ? '0 : 4'($urandom);
      addr = 4'($urandom);
      din  = $urandom;
   endtask

   // counts clear cycles from rst deassertion while throwing random accesses at the busy RAM
   task automatic clr_wait(input string tag);
      int n;
      n = 0;
      rst = 1'b0;
      while (busy_v[0] === 1'b1 && n < 40) begin
         rnd_in();
         step();
         n++;
      end
      chk(tag, n, DEPTH);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; we = '0; addr = '0; din = '0;
      step();
      step();
      for (int m = 0; m < 3; m++) begin
         chk("rst_dout", dout_v[m], '0);
         chk("rst_busy", {31'b0, busy_v[m]}, 32'd1);
      end
      clr_wait("clr_len_first");

      for (int a = 0; a < DEPTH; a++) wr(4'(a), 4'hF, 32'hFFFF_FFFF);
      rst = 1'b1; step();
      clr_wait("clr_len_preload");
      for (int a = 0; a < DEPTH; a++) begin
         rd(4'(a));
         for (int m = 0; m < 3; m++) chk("clr_zero", dout_v[m], '0);
      end

      wr(3, 4'hF, 32'hAABB_CCDD);
      wr(3, 4'b0101, 32'h1122_3344);
      chk("bw_wf", dout_v[0], 32'hAA22_CC44);
      chk("bw_rf", dout_v[1], 32'hAABB_CCDD);
      rd(3);
      for (int m = 0; m < 3; m++) chk("bw_read", dout_v[m], 32'hAA22_CC44);

      wr(5, 4'hF, 32'h1234_5678);
      wr(5, 4'hF, 32'hDEAD_BEEF);
      chk("rf_old", dout_v[1], 32'h1234_5678);
      rd(5);
      chk("rf_new", dout_v[1], 32'hDEAD_BEEF);

      wr(7, 4'hF, 32'h0000_CAFE);
      rd(7);
      chk("nc_read", dout_v[2], 32'h0000_CAFE);
      wr(8, 4'hF, 32'h0000_0001);
      chk("nc_write", dout_v[2], 32'h0000_CAFE);
      en = 1'b0; we = 4'hF; din = $urandom;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("nc_idle", dout_v[2], 32'h0000_CAFE);
      end
      rd(8);
      chk("en0_nowrite", dout_v[2], 32'h0000_0001);

      rst = 1'b1; step();
      rst = 1'b0;
      for (int k = 0; k < 7; k++) begin rnd_in(); step(); end
      rst = 1'b1; rnd_in(); step();
      clr_wait("clr_len_restart");
      for (int a = 0; a < DEPTH; a++) begin
         rd(4'(a));
         for (int m = 0; m < 3; m++) chk("restart_zero", dout_v[m], '0);
      end

      for (int k = 0; k < 400; k++) begin rnd_in(); step(); end

`ifdef MOR1KX_SPRAM_PARITY_EN
      begin
         logic [DW-1:0] v;
         v = $urandom;
         wr(2, 4'hF, v);
         g_dut[0].dut.mem[2][9] = ~g_dut[0].dut.mem[2][9];
         g_dut[1].dut.mem[2][9] = ~g_dut[1].dut.mem[2][9];
         g_dut[2].dut.mem[2][9] = ~g_dut[2].dut.mem[2][9];
         for (int m = 0; m < 3; m++) begin
            rmem[m][2][9] = ~rmem[m][2][9];
            rbad[m][2]    = rbad[m][2] | 4'b0010;
         end
         rd(2);
         for (int m = 0; m < 3; m++) chk("par_err", {31'b0, perr_v[m]}, 32'd1);
         wr(2, 4'hF, v);
         rd(2);
         for (int m = 0; m < 3; m++) chk("par_ok", {31'b0, perr_v[m]}, 32'd0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
